byte_to_word_converter: RTL and testbench
=========================================

// Module: byte_to_word_converter
// PURPOSE
// - Upsizing bridge: an 8-bit Avalon-MM master (legacy byte-wide DMA/device port) accesses a 32-bit
//   Avalon-MM slave with byteenable. Inverse direction of the existing 32->8 byteenable splitter.
// - Each byte request becomes exactly one word request with a one-hot byteenable. Pipelined reads
//   are tracked in a lane FIFO, and the correct byte lane is steered back to the master in order.
// PARAMETERS
// IADDR       32  upstream byte address width
// OADDR       32  downstream address width (byte address, word aligned)
// LANE_DEPTH  4   max outstanding reads; power of 2, >=2
// PORTS
// clk_sys            in   1      system clock
// rst                in   1      reset: synchronous, active-high
// addr_in            in   IADDR  upstream byte address
// write_in           in   1      upstream write request
// writedata_in       in   8      upstream write byte
// read_in            in   1      upstream read request
// readdata_out       out  8      returned byte
// readdatavalid_out  out  1      readdata_out valid, 1-cycle pulse per read
// waitrequest_out    out  1      upstream stall
// addr_out           out  OADDR  {addr_in[..:2],2'b00}, zero-extended or truncated to OADDR
// write_out          out  1      downstream write
// writedata_out      out  32     writedata_in replicated on all 4 lanes
// read_out           out  1      downstream read
// byteenable_out     out  4      1 << addr_in[1:0]
// readdata_in        in   32     downstream read word
// readdatavalid_in   in   1      downstream read data valid
// waitrequest_in     in   1      downstream stall
// BEHAVIOUR
// - Command path is combinational and adds zero latency. addr_out, byteenable_out and writedata_out
//   follow addr_in and writedata_in in the same cycle.
// - write_out = write_in. read_out = read_in && !write_in && !full. A simultaneous read_in+write_in
//   (protocol violation) gives the write priority and holds off the read.
// - waitrequest_out = waitrequest_in || (read_in && full). A full FIFO never stalls writes.
// - Read accept: read_out && !waitrequest_in pushes addr_in[1:0] into the lane FIFO.
// - Response: readdatavalid_in pops the FIFO head. One cycle later the block registers:
//   readdata_out <= readdata_in[8*lane +: 8]; readdatavalid_out <= 1.
//   readdatavalid_out is 0 in every other cycle. readdata_out holds its value between pulses.
// - Read latency = downstream latency + 1 clk_sys. Responses stay in request order.
// - Same-cycle push+pop: allowed when the FIFO is not full; count is unchanged.
//   When full: pop happens, push is blocked because read_out=0 this cycle. The read is accepted
//   next cycle.
// - readdatavalid_in while the FIFO is empty: ignored; no pulse, pointers unchanged.
// - Pointers wrap modulo LANE_DEPTH. full = (count==LANE_DEPTH); empty = (count==0).
// - Reset: readdata_out=0, readdatavalid_out=0, FIFO pointers/count=0.
//   A reset during outstanding reads discards their lanes. Late readdatavalid_in after reset is
//   dropped as empty.
// STRUCTURE
// - Shared header byteen_defs.vh: LANE_W=2, byte-lane index constants, ONEHOT_BE(lane) macro.
//   The existing 32->8 splitter uses the same header.
// - One sub-module: lane_fifo (sync FIFO, width LANE_W, depth LANE_DEPTH, push/pop/full/empty/count).
// - Top level holds the combinational command steering and the registered response mux.
// TESTING
// - Write addr_in=0x103, data=0xA5 -> same cycle: addr_out=0x100, byteenable_out=4'b1000,
//   writedata_out=0xA5A5A5A5, write_out=1.
// - Read 0x201, slave returns 0x44332211 two cycles later -> next cycle readdata_out=0x22,
//   readdatavalid_out=1 for exactly one cycle.
// - Four back-to-back reads (lanes 3,0,2,1), slave returns word 0xDDCCBBAA for each ->
//   bytes 0xDD,0xAA,0xCC,0xBB in order.
// - Issue 5 reads with no response (LANE_DEPTH=4) -> 5th read sees waitrequest_out=1 and
//   read_out=0. One response arrives -> 5th read is accepted the following cycle.
// - Assert rst with 2 reads outstanding, then drive readdatavalid_in -> readdatavalid_out stays 0;
//   a fresh read afterwards returns the correct lane.
// - waitrequest_in=1 during a read -> read_in held, no FIFO push until waitrequest_in falls;
//   exactly one response is returned.

Source files
------------

// File: rtl/byte_to_word_converter_pkg.sv
// -----------------------------------------------------------------------------
// byte_to_word_converter_pkg
// Shared byte-lane definitions for the 8<->32 Avalon-MM width bridges.
//   LANE_W       width of a byte-lane index within a 32-bit word
//   NUM_LANES    byte lanes per word
//   LANE_0..3    byte-lane index constants
//   onehot_be()  byteenable pattern selecting a single lane
// -----------------------------------------------------------------------------
package byte_to_word_converter_pkg;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = BYTE_W * NUM_LANES;

    localparam logic [LANE_W-1:0] LANE_0 = 2'd0;
    localparam logic [LANE_W-1:0] LANE_1 = 2'd1;
    localparam logic [LANE_W-1:0] LANE_2 = 2'd2;
    localparam logic [LANE_W-1:0] LANE_3 = 2'd3;

    function automatic logic [NUM_LANES-1:0] onehot_be(input logic [LANE_W-1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/byte_to_word_converter_lane_fifo.sv
// -----------------------------------------------------------------------------
// lane_fifo
// Small synchronous FIFO holding the byte-lane index of each outstanding read.
//   clk, rst     clock and synchronous active-high reset (pointers/count only)
//   push         write push_data (ignored when full)
//   push_data    lane index to store
//   pop          discard head entry (ignored when empty)
//   pop_data     head entry, valid whenever !empty
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module lane_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/byte_to_word_converter.sv
// -----------------------------------------------------------------------------
// byte_to_word_converter
// Upsizing bridge: a byte-wide Avalon-MM master reaches a 32-bit Avalon-MM
// slave. Each byte access becomes one word access with a one-hot byteenable;
// read lanes are queued so returned words are steered back in request order.
//   clk_sys, rst                      clock, synchronous active-high reset
//   addr_in, write_in, writedata_in,
//   read_in                           upstream byte-wide command
//   readdata_out, readdatavalid_out   upstream read response (1-cycle pulse)
//   waitrequest_out                   upstream stall
//   addr_out, write_out,
//   writedata_out, read_out,
//   byteenable_out                    downstream word command (combinational)
//   readdata_in, readdatavalid_in,
//   waitrequest_in                    downstream response / stall
// -----------------------------------------------------------------------------
module byte_to_word_converter
    import byte_to_word_converter_pkg::*;
#(
    parameter int IADDR      = 32,
    parameter int OADDR      = 32,
    parameter int LANE_DEPTH = 4
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [IADDR-1:0]     addr_in,
    input  logic                 write_in,
    input  logic [BYTE_W-1:0]    writedata_in,
    input  logic                 read_in,
    output logic [BYTE_W-1:0]    readdata_out,
    output logic                 readdatavalid_out,
    output logic                 waitrequest_out,
    output logic [OADDR-1:0]     addr_out,
    output logic                 write_out,
    output logic [WORD_W-1:0]    writedata_out,
    output logic                 read_out,
    output logic [NUM_LANES-1:0] byteenable_out,
    input  logic [WORD_W-1:0]    readdata_in,
    input  logic                 readdatavalid_in,
    input  logic                 waitrequest_in
);

    logic [IADDR-1:0]              word_addr;
    logic [LANE_W-1:0]             head_lane;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(LANE_DEPTH):0]   fifo_count;
    logic                          push;
    logic                          pop;

    // ---- command path (combinational, zero latency) ----
    assign word_addr      = {addr_in[IADDR-1:LANE_W], {LANE_W{1'b0}}};
    assign addr_out       = OADDR'(word_addr);
    assign byteenable_out = onehot_be(addr_in[LANE_W-1:0]);
    assign writedata_out  = {NUM_LANES{writedata_in}};
    assign write_out      = write_in;

    // A write that collides with a read wins; the read is simply not issued.
    assign read_out        = read_in && !write_in && !fifo_full;
    // Full lane queue stalls only reads; writes need no lane tracking.
    assign waitrequest_out = waitrequest_in || (read_in && fifo_full);

    assign push = read_out && !waitrequest_in;
    // Responses with nothing outstanding (e.g. after reset) are dropped.
    assign pop  = readdatavalid_in && !fifo_empty;

    lane_fifo #(
        .WIDTH (LANE_W),
        .DEPTH (LANE_DEPTH)
    ) u_lane_fifo (
        .clk       (clk_sys),
        .rst       (rst),
        .push      (push),
        .push_data (addr_in[LANE_W-1:0]),
        .pop       (pop),
        .pop_data  (head_lane),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---- response stage: registered lane mux ----
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            readdata_out      <= '0;
            readdatavalid_out <= 1'b0;
        end else begin
            readdatavalid_out <= pop;
            if (pop) begin
                readdata_out <= readdata_in[BYTE_W*head_lane +: BYTE_W];
            end
        end
    end

endmodule

// File: tb/tb_byte_to_word_converter.sv
module tb_byte_to_word_converter;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] addr_in;
    logic        write_in;
    logic [7:0]  writedata_in;
    logic        read_in;
    logic [7:0]  readdata_out;
    logic        readdatavalid_out;
    logic        waitrequest_out;
    logic [31:0] addr_out;
    logic        write_out;
    logic [31:0] writedata_out;
    logic        read_out;
    logic [3:0]  byteenable_out;
    logic [31:0] readdata_in;
    logic        readdatavalid_in;
    logic        waitrequest_in;

    int total = 0;
    int bad   = 0;

    // Reference model: lanes of outstanding reads in order, plus expected
    // state of the registered response outputs.
    int          lane_q[$];
    logic [7:0]  exp_rdata;
    logic        exp_vld;

    always #5 clk_sys = ~clk_sys;

    byte_to_word_converter #(
        .IADDR      (32),
        .OADDR      (32),
        .LANE_DEPTH (DEPTH)
    ) dut (
        .clk_sys           (clk_sys),
        .rst               (rst),
        .addr_in           (addr_in),
        .write_in          (write_in),
        .writedata_in      (writedata_in),
        .read_in           (read_in),
        .readdata_out      (readdata_out),
        .readdatavalid_out (readdatavalid_out),
        .waitrequest_out   (waitrequest_out),
        .addr_out          (addr_out),
        .write_out         (write_out),
        .writedata_out     (writedata_out),
        .read_out          (read_out),
        .byteenable_out    (byteenable_out),
        .readdata_in       (readdata_in),
        .readdatavalid_in  (readdatavalid_in),
        .waitrequest_in    (waitrequest_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst              = 1'b0;
        addr_in          = 32'h0;
        write_in         = 1'b0;
        writedata_in     = 8'h0;
        read_in          = 1'b0;
        readdata_in      = 32'h0;
        readdatavalid_in = 1'b0;
        waitrequest_in   = 1'b0;
    endtask

    // One clock: check command outputs against the model, advance the clock,
    // update the model, then check the registered response outputs.
    task automatic cycle(input string tag);
        logic       e_rd, e_wait, accept, popv;
        logic [7:0] pbyte;
        int         n;
        #1;
        n      = lane_q.size();
        e_rd   = read_in && !write_in && (n < DEPTH);
        e_wait = waitrequest_in || (read_in && (n == DEPTH));
        chk({tag, ":read_out"},        32'(read_out),        32'(e_rd));
        chk({tag, ":waitrequest_out"}, 32'(waitrequest_out), 32'(e_wait));
        chk({tag, ":write_out"},       32'(write_out),       32'(write_in));
        chk({tag, ":addr_out"},        addr_out,             addr_in & 32'hFFFF_FFFC);
        chk({tag, ":byteenable_out"},  32'(byteenable_out),  32'(1) << (addr_in % 4));
        chk({tag, ":writedata_out"},   writedata_out,        32'(writedata_in) * 32'h0101_0101);
        accept = e_rd && !waitrequest_in;
        popv   = readdatavalid_in && (n > 0);
        pbyte  = 8'h0;
        if (popv) pbyte = 8'((readdata_in / (32'd1 << (8 * lane_q[0]))) % 256);
        @(posedge clk_sys);
        if (rst) begin
            lane_q.delete();
            exp_rdata = 8'h0;
            exp_vld   = 1'b0;
        end else begin
            if (popv) begin
                void'(lane_q.pop_front());
                exp_rdata = pbyte;
            end
            if (accept) lane_q.push_back(int'(addr_in % 4));
            exp_vld = popv;
        end
        #1;
        chk({tag, ":readdatavalid_out"}, 32'(readdatavalid_out), 32'(exp_vld));
        chk({tag, ":readdata_out"},      32'(readdata_out),      32'(exp_rdata));
    endtask

    initial begin
        logic [7:0]  bytes4 [4];
        logic [31:0] lanes4 [4];
        exp_rdata = 8'h0;
        exp_vld   = 1'b0;
        idle();
        @(posedge clk_sys);
        #1;

        // Reset
        rst = 1'b1;
        cycle("reset0");
        cycle("reset1");
        idle();
        chk("reset:readdata_out", 32'(readdata_out), 32'h0);
        chk("reset:readdatavalid_out", 32'(readdatavalid_out), 32'h0);

        // Byte write to lane 3
        addr_in = 32'h103; writedata_in = 8'hA5; write_in = 1'b1;
        #1;
        chk("wr103:addr_out", addr_out, 32'h100);
        chk("wr103:byteenable_out", 32'(byteenable_out), 32'b1000);
        chk("wr103:writedata_out", writedata_out, 32'hA5A5_A5A5);
        chk("wr103:write_out", 32'(write_out), 32'h1);
        cycle("wr103");
        idle();

        // Read 0x201, slave answers two cycles later
        addr_in = 32'h201; read_in = 1'b1;
        cycle("rd201");
        idle();
        cycle("rd201_wait");
        readdata_in = 32'h4433_2211; readdatavalid_in = 1'b1;
        cycle("rd201_resp");
        chk("rd201:data", 32'(readdata_out), 32'h22);
        chk("rd201:pulse", 32'(readdatavalid_out), 32'h1);
        idle();
        cycle("rd201_after");
        chk("rd201:pulse_end", 32'(readdatavalid_out), 32'h0);

        // Four back-to-back reads, lanes 3,0,2,1
        lanes4 = '{32'h3, 32'h0, 32'h2, 32'h1};
        bytes4 = '{8'hDD, 8'hAA, 8'hCC, 8'hBB};
        for (int i = 0; i < 4; i++) begin
            idle();
            addr_in = 32'h300 + lanes4[i]; read_in = 1'b1;
            cycle("b2b_req");
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            readdata_in = 32'hDDCC_BBAA; readdatavalid_in = 1'b1;
            cycle("b2b_resp");
            chk("b2b:byte", 32'(readdata_out), 32'(bytes4[i]));
        end

        // Fill the lane queue, fifth read must stall until one response
        for (int i = 0; i < 4; i++) begin
            idle();
            addr_in = 32'h10 + 32'(i); read_in = 1'b1;
            cycle("fill_req");
        end
        idle();
        addr_in = 32'h16; read_in = 1'b1;
        #1;
        chk("full:waitrequest_out", 32'(waitrequest_out), 32'h1);
        chk("full:read_out", 32'(read_out), 32'h0);
        cycle("full_stall");
        readdata_in = 32'h8877_6655; readdatavalid_in = 1'b1;
        #1;
        chk("full_pop:read_out", 32'(read_out), 32'h0);
        cycle("full_pop");
        chk("full_pop:byte", 32'(readdata_out), 32'h55);
        readdatavalid_in = 1'b0;
        #1;
        chk("full_retry:read_out", 32'(read_out), 32'h1);
        chk("full_retry:waitrequest_out", 32'(waitrequest_out), 32'h0);
        cycle("full_retry");
        for (int i = 0; i < 4; i++) begin
            idle();
            readdata_in = 32'h4321_8765 + 32'(i); readdatavalid_in = 1'b1;
            cycle("full_drain");
        end
        chk("full_drain:last_byte", 32'(readdata_out), 32'h21);

        // Reset with two reads outstanding
        for (int i = 0; i < 2; i++) begin
            idle();
            addr_in = 32'h501 + 32'(i); read_in = 1'b1;
            cycle("rst_req");
        end
        idle();
        rst = 1'b1;
        cycle("rst_mid");
        idle();
        readdata_in = 32'h1234_5678; readdatavalid_in = 1'b1;
        cycle("rst_late0");
        chk("rst_late:pulse", 32'(readdatavalid_out), 32'h0);
        cycle("rst_late1");
        idle();
        addr_in = 32'h602; read_in = 1'b1;
        cycle("rst_fresh_req");
        idle();
        readdata_in = 32'hCAFE_BABE; readdatavalid_in = 1'b1;
        cycle("rst_fresh_resp");
        chk("rst_fresh:byte", 32'(readdata_out), 32'hFE);

        // Downstream stall during a read
        idle();
        addr_in = 32'h702; read_in = 1'b1; waitrequest_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall:waitrequest_out", 32'(waitrequest_out), 32'h1);
            cycle("stall_hold");
        end
        waitrequest_in = 1'b0;
        cycle("stall_release");
        idle();
        readdata_in = 32'h0BAD_F00D; readdatavalid_in = 1'b1;
        cycle("stall_resp");
        chk("stall:byte", 32'(readdata_out), 32'hAD);
        chk("stall:pulse", 32'(readdatavalid_out), 32'h1);
        cycle("stall_extra");
        chk("stall:single_pulse", 32'(readdatavalid_out), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            addr_in          = $urandom;
            writedata_in     = 8'($urandom);
            read_in          = ($urandom_range(0, 99) < 55);
            write_in         = ($urandom_range(0, 99) < 15);
            waitrequest_in   = ($urandom_range(0, 99) < 20);
            readdata_in      = $urandom;
            readdatavalid_in = ($urandom_range(0, 99) < 45);
            cycle("random");
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
